output_buffer: RTL

- Captures finished dot-product results from the accumulator's store port into a DEPTH-entry register file with one valid bit per entry.
- On command, drains a contiguous, wrapping address range as a valid/ready stream to the host/readout interface.
- Sits directly downstream of the accumulator. Its write port connects 1:1 to output_data / output_buffer_addr / output_buffer_enable.

---
 rtl/output_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/output_buffer.sv
// output_buffer: captures accumulator results into a DEPTH-entry register
// file with per-entry valid bits, and drains a wrapping address range as a
// valid/ready stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/addr/data     accumulator store port
//   drain_start/base/   drain command (IDLE only), first entry,
//   drain_count         entry count 0..DEPTH
//   out_data/valid/     registered stream output; out_last marks the
//   out_ready/out_last  final beat of a drain
//   drain_busy          FSM not IDLE
//   drain_done          one-cycle pulse at drain completion
//   occupancy           number of valid entries
//   overwrite_err       sticky: write hit a valid entry; err_clr clears
module output_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              drain_busy,
    output logic              drain_done,
    output logic [ADDR_W:0]   occupancy,
    output logic              overwrite_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W:0]   occ_nxt;

    logic start_ok;
    logic fetch_fire;
    logic hs;
    logic rem_one;

    assign start_ok   = (state == IDLE) && drain_start;
    assign fetch_fire = (state == FETCH) && valid[ptr];
    // out_valid is always high in PRESENT
    assign hs         = (state == PRESENT) && out_ready;
    assign rem_one    = (rem == (ADDR_W+1)'(1));

    assign drain_busy = (state != IDLE);
    assign drain_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (drain_start) begin
                    if (drain_count != '0) state_nxt = FETCH;
                    else                   state_nxt = DONE;
                end
            end
            FETCH: begin
                if (valid[ptr]) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (out_ready) state_nxt = rem_one ? DONE : FETCH;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A write to the entry being fetched wins the valid bit,
    // so the entry survives with the new data.
    always_comb begin
        valid_nxt = valid;
        if (fetch_fire) valid_nxt[ptr] = 1'b0;
        if (wr_en) valid_nxt[wr_addr] = 1'b1;
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + (ADDR_W+1)'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            occupancy     <= '0;
            overwrite_err <= 1'b0;
            ptr           <= '0;
            rem           <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            occupancy <= occ_nxt;
            if (wr_en && valid[wr_addr]) begin
                overwrite_err <= 1'b1;
            end else if (err_clr) begin
                overwrite_err <= 1'b0;
            end
            if (start_ok) begin
                ptr <= drain_base;
                rem <= drain_count;
            end
            if (fetch_fire) begin
                out_data  <= mem[ptr];
                out_valid <= 1'b1;
                out_last  <= rem_one;
            end
            if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                ptr       <= ptr + 1'b1;
                rem       <= rem - 1'b1;
            end
        end
    end

    // Contents survive reset; only valid bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule
